// File: rtl/aurora_pkg.sv
// aurora_pkg: NFC codes, entry width and FSM state type shared by the Aurora RX buffer.
package aurora_pkg;
    localparam int ENTRY_W = 65;
    localparam int NFC_XOFF_BIT = 8;
    localparam logic [15:0] NFC_XOFF = 16'(1) << NFC_XOFF_BIT;
    localparam logic [15:0] NFC_XON = 16'h0000;
    typedef enum logic [1:0] {RUN, XOFF_REQ, OFF, XON_REQ} nfc_state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with a registered first-word-fall-through head.
module sync_fifo_fwft
    import aurora_pkg::*;
#(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               dout_valid,
    output logic [AW:0]        level
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rd_next;
    logic [AW:0] remain;

    always_comb begin
        rd_next = pop ? rptr + 1'b1 : rptr;
        remain = level - (AW+1)'(pop);
    end

    always_ff @(posedge clk)
        if (push) mem[wptr] <= din;

    // the head register loads straight from din when nothing else is queued behind it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            dout <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            rptr <= rd_next;
            level <= remain + (AW+1)'(push);
            if (remain != '0) dout <= mem[rd_next];
            else if (push) dout <= din;
        end
    end

    assign dout_valid = level != '0;
endmodule

// File: rtl/aurora_rx_nfc_buffer.sv
// aurora_rx_nfc_buffer: Aurora RX elastic buffer with overflow flag and NFC XOFF/XON generation.
module aurora_rx_nfc_buffer
    import aurora_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int SKID = 48,
    parameter int XON_TH = 128,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [63:0]   RX_TDATA,
    input  logic          RX_TVALID,
    input  logic          RX_TLAST,
    output logic [63:0]   Q,
    output logic          Q_LAST,
    output logic          Q_VALID,
    input  logic          Q_BP,
    output logic          NFC_TVALID,
    output logic [15:0]   NFC_TDATA,
    input  logic          NFC_TREADY,
    output logic [LW-1:0] LEVEL,
    output logic          OVF,
    output logic          PAUSED
);
    logic push, pop;
    nfc_state_t state;

    always_comb begin
        pop = Q_VALID & ~Q_BP;
        push = RX_TVALID & ((LEVEL < LW'(DEPTH)) | pop);
    end

    sync_fifo_fwft #(.DEPTH(DEPTH)) u_fifo (
        .clk(CLK),
        .rst_n(RST_X),
        .push(push),
        .pop(pop),
        .din({RX_TLAST, RX_TDATA}),
        .dout({Q_LAST, Q}),
        .dout_valid(Q_VALID),
        .level(LEVEL)
    );

    always_ff @(posedge CLK) begin
        if (!RST_X) OVF <= 1'b0;
        else if (RX_TVALID & ~push) OVF <= 1'b1;
    end

    // requests are raised once and held until the core takes them
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state <= RUN;
            NFC_TVALID <= 1'b0;
            NFC_TDATA <= NFC_XON;
            PAUSED <= 1'b0;
        end else begin
            case (state)
                RUN: if (LEVEL >= LW'(DEPTH - SKID)) begin
                    state <= XOFF_REQ;
                    NFC_TVALID <= 1'b1;
                    NFC_TDATA <= NFC_XOFF;
                end
                XOFF_REQ: if (NFC_TREADY) begin
                    state <= OFF;
                    NFC_TVALID <= 1'b0;
                    PAUSED <= 1'b1;
                end
                OFF: if (LEVEL <= LW'(XON_TH)) begin
                    state <= XON_REQ;
                    NFC_TVALID <= 1'b1;
                    NFC_TDATA <= NFC_XON;
                end
                XON_REQ: if (NFC_TREADY) begin
                    state <= RUN;
                    NFC_TVALID <= 1'b0;
                    PAUSED <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
